// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: I/O offsets,
// STATUS bit positions and ready-FSM state encodings.
package mem_responder_pkg;

  localparam logic [1:0] IO_TXDATA = 2'd0;
  localparam logic [1:0] IO_STATUS = 2'd1;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;

  typedef enum logic [1:0] {
    RDY_RESET = 2'd0,
    RDY_CLEAR = 2'd1,
    RDY_READY = 2'd2
  } rdy_state_e;

  function automatic logic [7:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [4:0] cnt
  );
    logic [7:0] s;
    s                = '0;
    s[ST_FULL]       = full;
    s[ST_EMPTY]      = empty;
    s[ST_OVF]        = ovf;
    s[7:ST_CNT_LSB]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// byte_fifo: small registered byte queue with wrap-around pointers.
// A push into a full queue is taken only when a pop happens alongside it.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: block RAM, top-of-space I/O window, TX FIFO.
// Optional RAM_CLEAR_EN zeroes the RAM after every reset release.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int addr_width = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] mem_raddr,
  output logic [7:0]            mem_data_out,
  input  logic [addr_width-1:0] mem_waddr,
  input  logic [7:0]            mem_data_in,
  input  logic                  mem_write,
  output logic                  mem_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int IO_BASE = 2**addr_width - 4;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  rdy_state_e state_q, state_d;
  logic       mem_ready_q, mem_ready_d;
  logic       ovf_q, ovf_d;
  logic       sel_ram_q, sel_ram_d;
  logic [7:0] io_rd_q, io_rd_d;
  logic [7:0] ram_rd_q;

  logic                  io_r, io_w;
  logic                  rd_ok, wr_ok;
  logic                  status_rd;
  logic                  ram_we;
  logic [addr_width-1:0] ram_wa;
  logic [7:0]            ram_wd;
  logic [7:0]            status;

  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;

  logic [7:0] ram [2**addr_width];

`ifdef RAM_CLEAR_EN
  localparam logic [addr_width-1:0] LAST_CLR =
    addr_width'(IO_BASE - 1);
  logic [addr_width-1:0] clr_q, clr_d;
`endif

  assign io_r  = &mem_raddr[addr_width-1:2];
  assign io_w  = &mem_waddr[addr_width-1:2];
  assign rd_ok = (state_q == RDY_READY);
  assign wr_ok = mem_write & (state_q == RDY_READY);

  assign fifo_push = wr_ok & io_w & (mem_waddr[1:0] == IO_TXDATA);
  assign fifo_pop  = ~fifo_empty & tx_ready;

  assign status = pack_status(fifo_full, fifo_empty, ovf_q, 5'(fifo_cnt));

  assign mem_ready    = mem_ready_q;
  assign tx_valid     = ~fifo_empty;
  assign mem_data_out = sel_ram_q ? ram_rd_q : io_rd_q;

  // Ready sequencing: RESET, optionally CLEAR, then READY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef RAM_CLEAR_EN
      RDY_RESET: state_d = RDY_CLEAR;
      RDY_CLEAR: if (clr_q == LAST_CLR) state_d = RDY_READY;
`else
      RDY_RESET: state_d = RDY_READY;
`endif
      default:   state_d = RDY_READY;
    endcase
    mem_ready_d = (state_d == RDY_READY);
  end

`ifdef RAM_CLEAR_EN
  // Clear address walks the RAM region while in CLEAR.
  always_comb begin
    clr_d = clr_q;
    if (state_q == RDY_CLEAR) clr_d = clr_q + 1'b1;
  end

  // Clear address register, restarts from zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_q <= '0;
    else       clr_q <= clr_d;
  end
`endif

  // RAM write port: clear engine owns it during CLEAR.
  always_comb begin
    ram_we = wr_ok & ~io_w;
    ram_wa = mem_waddr;
    ram_wd = mem_data_in;
`ifdef RAM_CLEAR_EN
    if (state_q == RDY_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = clr_q;
      ram_wd = '0;
    end
`endif
  end

  // Read decode: RAM, STATUS, or zero for everything else.
  always_comb begin
    sel_ram_d = 1'b0;
    io_rd_d   = '0;
    status_rd = 1'b0;
    if (rd_ok) begin
      unique case (1'b1)
        !io_r: sel_ram_d = 1'b1;
        io_r && (mem_raddr[1:0] == IO_STATUS): begin
          io_rd_d   = status;
          status_rd = 1'b1;
        end
        default: io_rd_d = '0;
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared by a STATUS read.
  always_comb begin
    ovf_d = (ovf_q & ~status_rd)
          | (fifo_push & fifo_full & ~fifo_pop);
  end

  // Control and read-select registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RDY_RESET;
      mem_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      sel_ram_q   <= 1'b0;
      io_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      ovf_q       <= ovf_d;
      sel_ram_q   <= sel_ram_d;
      io_rd_q     <= io_rd_d;
    end
  end

  // Block RAM, read-first, contents never reset.
  always_ff @(posedge clk) begin
    ram_rd_q <= ram[mem_raddr];
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_data_in),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Build with +define+RAM_CLEAR_EN to cover the clear sequence.
module tb_mem_responder;

  localparam int AW = 9;
`ifdef RAM_CLEAR_EN
  localparam int EXP_RDY = 509;
`else
  localparam int EXP_RDY = 1;
`endif
  localparam logic [AW-1:0] A_TX = 9'h1FC;
  localparam logic [AW-1:0] A_ST = 9'h1FD;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_data_out;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_data_in;
  logic          mem_write;
  logic          mem_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_rdy;

  always #5 clk = ~clk;

  mem_responder #(
    .addr_width (AW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_raddr    (mem_raddr),
    .mem_data_out (mem_data_out),
    .mem_waddr    (mem_waddr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_ready    (mem_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    mem_write   = 1'b1;
    mem_waddr   = a;
    mem_data_in = d;
    step();
    mem_write   = 1'b0;
  endtask

  task automatic release_wait(output int n);
    reset = 1'b0;
    n = 0;
    while (!mem_ready && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_data_in = '0;
    mem_write   = 1'b0;
    tx_ready    = 1'b0;
    repeat (3) step();

    check("rst_ready", 16'(mem_ready), 16'h0);
    check("rst_valid", 16'(tx_valid), 16'h0);
    check("rst_data", 16'(mem_data_out), 16'h0);

    // 1: ready timing
    release_wait(n_rdy);
    check("rdy_cycles", 16'(n_rdy), 16'(EXP_RDY));
`ifdef RAM_CLEAR_EN
    mem_raddr = 9'h0A0;
    step();
    check("clr_0a0", 16'(mem_data_out), 16'h00);
`endif

    // 2: pipelined reads
    wr(9'h010, 8'h12);
    wr(9'h011, 8'h34);
    mem_raddr = 9'h010;
    step();
    check("pipe_rd0", 16'(mem_data_out), 16'h12);
    mem_raddr = 9'h011;
    #1;
    check("pipe_lat", 16'(mem_data_out), 16'h12);
    step();
    check("pipe_rd1", 16'(mem_data_out), 16'h34);

    // 3: read-first
    wr(9'h020, 8'h55);
    mem_raddr = 9'h020;
    wr(9'h020, 8'hAA);
    check("rf_old", 16'(mem_data_out), 16'h55);
    step();
    check("rf_new", 16'(mem_data_out), 16'hAA);

    // empty status and TXDATA read
    mem_raddr = A_ST;
    step();
    check("st_empty", 16'(mem_data_out), 16'h02);
    mem_raddr = A_TX;
    step();
    check("txd_rd", 16'(mem_data_out), 16'h00);

    // 4: fill and overflow
    mem_raddr = 9'h010;
    wr(A_TX, 8'h41);
    check("push_valid", 16'(tx_valid), 16'h1);
    check("push_head", 16'(tx_data), 16'h41);
    for (int i = 1; i < 5; i++) wr(A_TX, 8'(8'h41 + i));
    mem_raddr = A_ST;
    step();
    check("st_ovf", 16'(mem_data_out), 16'h25);
    step();
    check("st_ovf_clr", 16'(mem_data_out), 16'h21);
    mem_raddr = 9'h010;
    tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_v", 16'(tx_valid), 16'h1);
      check("drain_d", 16'(tx_data), 16'(8'h41 + i));
      step();
    end
    check("drain_end", 16'(tx_valid), 16'h0);
    tx_ready = 1'b0;

    // 5: full with push and pop together
    for (int i = 0; i < 4; i++) wr(A_TX, 8'(8'h61 + i));
    tx_ready = 1'b1;
    wr(A_TX, 8'h65);
    tx_ready  = 1'b0;
    mem_raddr = A_ST;
    step();
    check("st_pp", 16'(mem_data_out), 16'h21);
    mem_raddr = 9'h010;
    tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_d", 16'(tx_data), 16'(8'h62 + i));
      step();
    end
    check("pp_end", 16'(tx_valid), 16'h0);
    tx_ready = 1'b0;

    // 6: reset mid-operation
    wr(A_TX, 8'h71);
    wr(A_TX, 8'h72);
    check("q2_valid", 16'(tx_valid), 16'h1);
    check("q2_data", 16'(mem_data_out), 16'h12);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_valid", 16'(tx_valid), 16'h0);
    check("ar_ready", 16'(mem_ready), 16'h0);
    check("ar_data", 16'(mem_data_out), 16'h0);
    step();
`ifdef RAM_CLEAR_EN
    reset = 1'b0;
    repeat (100) step();
    check("mid_clr", 16'(mem_ready), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
`endif
    release_wait(n_rdy);
    check("rdy2_cycles", 16'(n_rdy), 16'(EXP_RDY));
    mem_raddr = A_ST;
    step();
    check("st_after_rst", 16'(mem_data_out), 16'h02);
    mem_raddr = 9'h010;
    step();
`ifdef RAM_CLEAR_EN
    check("ram_cleared", 16'(mem_data_out), 16'h00);
`else
    check("ram_kept", 16'(mem_data_out), 16'h12);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
